// File: rtl/ctr_pkg.sv
// ctr_pkg: shared definitions for the T-flop based up/down counter.
//   CNT_UP / CNT_DN : encodings of the up_dn direction input.
//   clamp()         : saturates a parallel-load value to the terminal count.
package ctr_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   function automatic int unsigned clamp(input int unsigned val, input int unsigned max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with synchronous reset and parallel load.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear (highest priority)
//   ld    : synchronous load of d
//   d     : load data
//   t     : toggle when high
//   q     : registered state
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic ld,
   input  logic d,
   input  logic t,
   output logic q
);

   logic q_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 1'b0;
      end else if (ld) begin
         q_q <= d;
      end else if (t) begin
         q_q <= ~q_q;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: modulo (0..MOD_MAX) up/down counter built from one
// tff_cell per bit. The next count is computed arithmetically and turned into
// a per-bit toggle vector; load and reset use the cells' override inputs.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset (q=0, wrap=0)
//   en       : count enable
//   up_dn    : direction, CNT_UP counts up, CNT_DN counts down
//   load     : parallel load strobe (value clamped to MOD_MAX)
//   load_val : parallel load value
//   q        : current count
//   t_vec    : toggle vector applied at the next edge
//   tc       : terminal count for the current direction
//   wrap     : one-cycle pulse after the count wrapped
module tff_updown_counter
   import ctr_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MOD_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t_vec,
   output logic             tc,
   output logic             wrap
);

   if (MOD_MAX < 1 || MOD_MAX > (2 ** WIDTH) - 1) begin : g_bad_mod_max
      $error("tff_updown_counter: MOD_MAX out of range 1..2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] step_d;
   logic [WIDTH-1:0] load_d;
   logic             step_wrap;
   logic             cnt_en;
   logic             wrap_d;
   logic             wrap_q;

   assign load_d = WIDTH'(clamp(32'(load_val), 32'(MOD_MAX)));
   assign cnt_en = en & ~load & ~reset;

   // Counting up from any state at or above MAX_V wraps to 0, so a faulted
   // out-of-range state recovers on the next up-step.
   always_comb begin
      step_d    = cnt_q;
      step_wrap = 1'b0;
      if (up_dn == CNT_UP) begin
         if (cnt_q >= MAX_V) begin
            step_d    = '0;
            step_wrap = 1'b1;
         end else begin
            step_d = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == '0) begin
            step_d    = MAX_V;
            step_wrap = 1'b1;
         end else begin
            step_d = cnt_q - 1'b1;
         end
      end
   end

   assign t_vec  = cnt_en ? (cnt_q ^ step_d) : '0;
   assign wrap_d = cnt_en & step_wrap;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .ld    (load),
         .d     (load_d[i]),
         .t     (t_vec[i]),
         .q     (cnt_q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign q    = cnt_q;
   assign wrap = wrap_q;
   assign tc   = (up_dn == CNT_UP) ? (cnt_q == MAX_V) : (cnt_q == '0);

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: scoreboard bench for tff_updown_counter (WIDTH=4,
// MOD_MAX=9). The driver issues one input set per cycle and pushes the
// expected outputs from an integer model; the monitor pops and compares.
module tb_tff_updown_counter;

   localparam int W  = 4;
   localparam int MM = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         up_dn = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic [W-1:0] t_vec;
   logic         tc;
   logic         wrap;

   typedef struct {
      bit chk_comb;
      int tc_exp;
      int tv_exp;
      int q_exp;
      int wrap_exp;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   m_q = 0;
   bit   m_known = 0;
   bit   drv_done = 0;

   always #5 clk = ~clk;

   tff_updown_counter #(.WIDTH(W), .MOD_MAX(MM)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .t_vec    (t_vec),
      .tc       (tc),
      .wrap     (wrap)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and record what the design must do with them.
   task automatic step(input bit r, input bit l, input int lv, input bit e, input bit ud);
      exp_t x;
      int   n;
      int   w;
      @(negedge clk);
      reset    = r;
      load     = l;
      load_val = W'(lv);
      en       = e;
      up_dn    = ud;
      n = m_q;
      w = 0;
      if (r) begin
         n = 0;
      end else if (l) begin
         n = (lv > MM) ? MM : lv;
      end else if (e) begin
         if (ud) begin
            if (m_q >= MM) begin n = 0; w = 1; end
            else n = m_q + 1;
         end else begin
            if (m_q == 0) begin n = MM; w = 1; end
            else n = m_q - 1;
         end
      end
      x.chk_comb = m_known;
      x.tc_exp   = ud ? int'(m_q == MM) : int'(m_q == 0);
      x.tv_exp   = (r || l || !e) ? 0 : (m_q ^ n);
      x.q_exp    = n;
      x.wrap_exp = w;
      sb.push_back(x);
      m_q = n;
      if (r) m_known = 1;
   endtask

   // Monitor: combinational outputs just after the inputs settle, registered
   // outputs just after the following edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.chk_comb) begin
               check("tc", int'(tc), x.tc_exp);
               check("t_vec", int'(t_vec), x.tv_exp);
            end
            @(posedge clk);
            #1;
            check("q", int'(q), x.q_exp);
            check("wrap", int'(wrap), x.wrap_exp);
         end
      end
   end

   initial begin
      // Reset, then count up through the wrap.
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
      // Load 3 and count down through 0 -> 9.
      step(0, 1, 3, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      // Clamped load with en ignored.
      step(0, 1, 14, 1, 1);
      // Load beats en; reset beats load and en.
      step(0, 1, 5, 0, 1);
      step(0, 1, 2, 1, 1);
      step(1, 1, 7, 1, 1);
      // Up to 7, hold, then alternate direction.
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      // Reach 9, reset with en high, release.
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(19) == 0, $urandom_range(7) == 0, int'($urandom_range(15)),
              $urandom_range(3) != 0, 1'($urandom_range(1)));
      end
      step(0, 0, 0, 0, 1);
      drv_done = 1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
